// File: rtl/csa_resolve_180_pkg.sv
// Shared constants for the 89x89 multiplier datapath.
// Operand widths, CSA output width and CPA segmenting.
package csa_resolve_180_pkg;

   localparam int MUL_OP_W    = 89;
   localparam int MUL_PROD_W  = 2 * MUL_OP_W;
   localparam int WIDTH_180   = 180;
   localparam int SEG_DEFAULT = 45;

   function automatic int nseg_of(input int w, input int s);
      return w / s;
   endfunction

endpackage

// File: rtl/csa_resolve_slice.sv
// One SEG-bit ripple slice of the resolving adder.
// Ports: a, b, cin in; sum (SEG bits), cout out.
module csa_resolve_slice
   import csa_resolve_180_pkg::*;
#(
   parameter int SEG = SEG_DEFAULT
) (
   input  logic [SEG-1:0] a,
   input  logic [SEG-1:0] b,
   input  logic           cin,
   output logic [SEG-1:0] sum,
   output logic           cout
);

   assign {cout, sum} = {1'b0, a} + {1'b0, b}
                      + {{SEG{1'b0}}, cin};

endmodule

// File: rtl/csa_resolve_180.sv
// Pipelined segmented CPA: resolves a CSA (c, s) pair into c + s.
// Ports: clk, rst_n; in_valid/in_ready/in_c/in_s; out_valid/out_ready/out_sum/out_carry.
module csa_resolve_180
   import csa_resolve_180_pkg::*;
#(
   parameter int WIDTH = WIDTH_180,
   parameter int SEG   = SEG_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_c,
   input  logic [WIDTH-1:0] in_s,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_carry
);

   localparam int NSEG = nseg_of(WIDTH, SEG);

   if (WIDTH % SEG != 0) begin : g_chk
      $error("csa_resolve_180: WIDTH must be a multiple of SEG");
   end

   logic [NSEG-1:0] vld;
   logic [NSEG-1:0] adv;

   for (genvar k = 0; k < NSEG; k++) begin : g_stg
      localparam int LW = (k + 1) * SEG;
      localparam int UW = WIDTH - LW;
      localparam int QW = LW + 2 * UW;

      // q packs {pc, ps, res}: unresolved upper c/s bits
      // above the resolved low LW bits.
      logic [QW-1:0]  q;
      logic [QW-1:0]  d;
      logic           vq;
      logic           cq;
      logic           vin;
      logic           ci;
      logic           co;
      logic [SEG-1:0] a;
      logic [SEG-1:0] b;
      logic [SEG-1:0] s;

      // Closed form of the ready chain: stage k may move
      // if any stage from k to the end has a hole.
      assign adv[k] = out_ready | ~(&vld[NSEG-1:k]);
      assign vld[k] = vq;

      if (k == 0) begin : g_head
         assign a   = in_c[SEG-1:0];
         assign b   = in_s[SEG-1:0];
         assign ci  = 1'b0;
         assign vin = in_valid;
         if (UW > 0) begin : g_up
            assign d = {in_c[WIDTH-1:SEG], in_s[WIDTH-1:SEG], s};
         end else begin : g_end
            assign d = s;
         end
      end else begin : g_body
         localparam int PL = k * SEG;
         localparam int PU = WIDTH - PL;
         logic [PL+2*PU-1:0] p;

         assign p   = g_stg[k-1].q;
         assign ci  = g_stg[k-1].cq;
         assign vin = g_stg[k-1].vq;
         assign b   = p[PL +: SEG];
         assign a   = p[PL+PU +: SEG];
         if (UW > 0) begin : g_up
            assign d = {p[PL+PU+SEG +: UW],
                        p[PL+SEG +: UW],
                        s, p[PL-1:0]};
         end else begin : g_end
            assign d = {s, p[PL-1:0]};
         end
      end

      csa_resolve_slice #(.SEG(SEG)) u_slice (
         .a    (a),
         .b    (b),
         .cin  (ci),
         .sum  (s),
         .cout (co)
      );

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            vq <= 1'b0;
            cq <= 1'b0;
            q  <= '0;
         end else if (adv[k]) begin
            vq <= vin;
            cq <= co;
            q  <= d;
         end
      end
   end

   assign in_ready  = adv[0];
   assign out_valid = vld[NSEG-1];
   assign out_sum   = g_stg[NSEG-1].q;
   assign out_carry = g_stg[NSEG-1].cq;

endmodule

// File: tb/tb_csa_resolve_180.sv
// Directed and streaming checks for csa_resolve_180.
// Drives after posedge+1, samples before the next edge.
module tb_csa_resolve_180;

   localparam int W    = 180;
   localparam int NSEG = 4;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_c;
   logic [W-1:0]  in_s;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_sum;
   logic          out_carry;

   int vectors = 0;
   int miscompares = 0;
   int sent = 0;
   logic [W:0] expq[$];

   csa_resolve_180 dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_c      (in_c),
      .in_s      (in_s),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_carry (out_carry)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [W:0] got,
                        input logic [W:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] rnd180();
      logic [W-1:0] r;
      r = '0;
      for (int i = 0; i < 6; i++) r = (r << 32) | W'($urandom());
      return r;
   endfunction

   // Random pair shaped like a real CSA output (carry bit 0 = 0).
   task automatic csa_pair(output logic [W-1:0] c, output logic [W-1:0] s);
      logic [W-1:0] x, y, z;
      x = rnd180();
      y = rnd180();
      z = rnd180();
      s = x ^ y ^ z;
      c = ((x & y) | (x & z) | (y & z)) << 1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_pair(input string tag, input logic [W-1:0] c,
                           input logic [W-1:0] s, input logic [W:0] exp);
      in_c = c;
      in_s = s;
      in_valid = 1'b1;
      out_ready = 1'b1;
      #1;
      check({tag, " in_ready"}, W'(in_ready), 1);
      tick();
      in_valid = 1'b0;
      check({tag, " lat1"}, W'(out_valid), 0);
      tick();
      check({tag, " lat2"}, W'(out_valid), 0);
      tick();
      check({tag, " lat3"}, W'(out_valid), 0);
      tick();
      check({tag, " valid"}, W'(out_valid), 1);
      check({tag, " result"}, {out_carry, out_sum}, exp);
      tick();
      check({tag, " drain"}, W'(out_valid), 0);
   endtask

   task automatic stream(input int n, input bit rnd, input int maxcyc,
                         output int cyc);
      logic [W-1:0] c, s;
      logic [W:0]   hv;
      logic         hold;
      cyc = 0;
      while ((sent < n || expq.size() > 0) && cyc < maxcyc) begin
         if (sent < n && (!rnd || $urandom_range(0, 3) != 0)) begin
            csa_pair(c, s);
            in_c = c;
            in_s = s;
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         #1;
         if (out_valid && out_ready) begin
            if (expq.size() == 0) begin
               check("stream extra output", W'(out_valid), 0);
            end else begin
               check("stream data", {out_carry, out_sum}, expq.pop_front());
            end
         end
         if (in_valid && in_ready) begin
            expq.push_back({1'b0, in_c} + {1'b0, in_s});
            sent++;
         end
         hold = out_valid && !out_ready;
         hv = {out_carry, out_sum};
         tick();
         if (hold) begin
            check("stall valid", W'(out_valid), 1);
            check("stall data", {out_carry, out_sum}, hv);
         end
         cyc++;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      check("stream all sent", W'(sent), W'(n));
      check("stream all drained", W'(expq.size()), 0);
   endtask

   initial begin
      int cyc;
      int acc;
      logic [W-1:0] c, s;
      logic [W:0]   e;

      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      in_c = '0;
      in_s = '0;
      #12;
      check("rst out_valid", W'(out_valid), 0);
      check("rst out_sum", {1'b0, out_sum}, 0);
      check("rst out_carry", W'(out_carry), 0);
      rst_n = 1'b1;
      #1;
      check("rst in_ready", W'(in_ready), 1);
      tick();

      // Directed vectors
      run_pair("simple", '0, W'(36'h123456789), (W+1)'(36'h123456789));
      s = '1;
      e = '0;
      e[W] = 1'b1;
      run_pair("full ripple", W'(1), s, e);
      s = '0;
      s[44:0] = '1;
      e = '0;
      e[45] = 1'b1;
      run_pair("seg45", W'(1), s, e);
      s = '0;
      s[89:0] = '1;
      e = '0;
      e[90] = 1'b1;
      run_pair("seg90", W'(1), s, e);
      c = '1;
      s = '1;
      e = '1;
      e[0] = 1'b0;
      run_pair("all ones", c, s, e);

      // Streaming at full rate: 100 results, 4-cycle fill
      sent = 0;
      stream(100, 1'b0, 500, cyc);
      check("stream cycles", W'(cyc), W'(100 + NSEG));

      // Backpressure: exactly NSEG accepts with out_ready low
      sent = 0;
      acc = 0;
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         csa_pair(c, s);
         in_c = c;
         in_s = s;
         in_valid = 1'b1;
         #1;
         if (in_ready) begin
            expq.push_back({1'b0, c} + {1'b0, s});
            sent++;
            acc++;
         end
         tick();
      end
      check("bp accepts", W'(acc), W'(NSEG));
      check("bp in_ready low", W'(in_ready), 0);
      check("bp out_valid", W'(out_valid), 1);
      out_ready = 1'b1;
      #1;
      check("bp in_ready comb", W'(in_ready), 1);
      stream(40, 1'b1, 2000, cyc);

      // Reset with three pairs in flight
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         csa_pair(c, s);
         in_c = c;
         in_s = s;
         in_valid = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst out_valid", W'(out_valid), 0);
      check("midrst out_sum", {out_carry, out_sum}, 0);
      check("midrst in_ready", W'(in_ready), 1);
      #3;
      rst_n = 1'b1;
      #1;
      check("post rst in_ready", W'(in_ready), 1);
      check("post rst out_valid", W'(out_valid), 0);
      tick();
      c = '0;
      c[100] = 1'b1;
      s = '0;
      s[100] = 1'b1;
      s[3:0] = 4'h5;
      e = '0;
      e[101] = 1'b1;
      e[3:0] = 4'h5;
      run_pair("post rst first", c, s, e);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
